// File: rtl/fb_pkg.sv
// Shared framebuffer constants, write-path FSM encoding and
// the latched write bundle used by the write-port arbiter.
package fb_pkg;

    localparam int FB_COORD_W = 8;
    localparam int FB_DATA_W  = 8;
    localparam int FB_WIDTH   = 128;
    localparam int FB_HEIGHT  = 64;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_FB = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        WAIT_FB = ST_WAIT_FB,
        WRITE   = ST_WRITE,
        RELEASE = ST_RELEASE
    } fb_wr_state_t;

    typedef struct packed {
        logic [FB_COORD_W-1:0] xpos;
        logic [FB_COORD_W-1:0] ypos;
        logic [FB_DATA_W-1:0]  din;
    } fb_wr_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first set request at or
// above the pointer, wrapping from N-1 back to 0.
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    logic found;
    int   j;

    always_comb begin
        onehot    = '0;
        idx       = '0;
        any_valid = |req;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin sequencer sharing the framebuffer write port among
// NREQ pixel writers, with done/err pulses and a stuck-ack watchdog.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [8*NREQ-1:0]     req_xpos,
    input  logic [8*NREQ-1:0]     req_ypos,
    input  logic [8*NREQ-1:0]     req_din,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_err,
    output logic [NREQ-1:0]       grant,
    input  logic                  fb_busy,
    input  logic                  fb_w_data_valid,
    output logic                  fb_we,
    output logic [FB_COORD_W-1:0] fb_w_xpos,
    output logic [FB_COORD_W-1:0] fb_w_ypos,
    output logic [FB_DATA_W-1:0]  fb_din,
    output logic                  timeout_flag
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    fb_wr_state_t    state, state_d;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   nxt_ptr;
    logic [TW-1:0]   wdog;
    fb_wr_t          wr_q;
    fb_wr_t          sel;

    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            any_valid;

    logic do_latch;
    logic do_start;
    logic do_done;
    logic do_abort;
    logic do_release;

    rr_priority_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .onehot    (win_oh),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // One-hot mux of the winner's packed fields.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel.xpos = req_xpos[8*i +: 8];
                sel.ypos = req_ypos[8*i +: 8];
                sel.din  = req_din[8*i +: 8];
            end
        end
    end

    assign nxt_ptr = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_d    = state;
        do_latch   = 1'b0;
        do_start   = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        do_release = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    do_latch = 1'b1;
                    state_d  = WAIT_FB;
                end
            end
            WAIT_FB: begin
                if (!fb_busy) begin
                    do_start = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                // An ack on the terminal watchdog cycle still wins.
                if (fb_w_data_valid) begin
                    do_done = 1'b1;
                    state_d = RELEASE;
                end else if (wdog == TW'(TIMEOUT-1)) begin
                    do_abort = 1'b1;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                do_release = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            wdog         <= '0;
            wr_q         <= '0;
            grant        <= '0;
            fb_we        <= 1'b0;
            req_done     <= '0;
            req_err      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_d;
            req_done <= '0;
            req_err  <= '0;
            if (do_latch) begin
                wr_q  <= sel;
                grant <= win_oh;
                owner <= win_idx;
            end
            if (do_start) begin
                fb_we <= 1'b1;
                wdog  <= '0;
            end
            if (state == WRITE) begin
                wdog <= wdog + 1'b1;
            end
            if (do_done || do_abort) begin
                fb_we  <= 1'b0;
                rr_ptr <= nxt_ptr;
            end
            if (do_done) begin
                req_done <= grant;
            end
            if (do_abort) begin
                req_err      <= grant;
                timeout_flag <= 1'b1;
            end
            if (do_release) begin
                grant <= '0;
            end
        end
    end

    assign fb_w_xpos = wr_q.xpos;
    assign fb_w_ypos = wr_q.ypos;
    assign fb_din    = wr_q.din;

endmodule
